// File: rtl/t06_wall_placer_if.sv
// Request/result bundle for the wall placer: latched inputs in, wall table and status out.
interface t06_wall_placer_if;
  logic         start;
  logic [4:0]   target_count;
  logic [7:0]   snake_head;
  logic [7:0]   apple;
  logic [199:0] walls;
  logic [4:0]   wall_count;
  logic         busy;
  logic         done;
  logic         aborted;

  modport master (
    output start, target_count, snake_head, apple,
    input  walls, wall_count, busy, done, aborted
  );

  modport slave (
    input  start, target_count, snake_head, apple,
    output walls, wall_count, busy, done, aborted
  );
endinterface

// File: rtl/t06_wall_placer.sv
// Places up to 25 distinct pseudo-random walls, avoiding the snake head and apple,
// using a free-running Galois LFSR as the candidate source.
module t06_wall_placer (
  input  logic               clk,
  input  logic               nRst,
  t06_wall_placer_if.slave   bus
);
  localparam int          SLOTS   = 25;
  localparam logic [7:0]  EMPTY   = 8'hFF;
  localparam logic [4:0]  MAX_TGT = 5'd25;

  typedef enum logic [1:0] {IDLE, CLEAR, GEN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              lfsr_q, lfsr_d;
  logic [SLOTS-1:0][7:0]   walls_q, walls_d;
  logic [4:0]              idx_q, idx_d;
  logic [4:0]              tgt_q, tgt_d;
  logic [7:0]              head_q, head_d;
  logic [7:0]              apple_q, apple_d;
  logic [5:0]              rej_q, rej_d;
  logic                    aborted_q, aborted_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [SLOTS-1:0]        hit;
  logic                    rej_c;

  assign lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

  // Only slots already filled this run take part in the duplicate check.
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign hit[i] = (5'(i) < idx_q) && (walls_q[i] == lfsr_q);
  end

  assign rej_c = (lfsr_q == EMPTY) || (lfsr_q == head_q) || (lfsr_q == apple_q) || (|hit);

  always_comb begin
    state_d   = state_q;
    walls_d   = walls_q;
    idx_d     = idx_q;
    tgt_d     = tgt_q;
    head_d    = head_q;
    apple_d   = apple_q;
    rej_d     = rej_q;
    aborted_d = aborted_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d   = CLEAR;
        tgt_d     = (bus.target_count > MAX_TGT) ? MAX_TGT : bus.target_count;
        head_d    = bus.snake_head;
        apple_d   = bus.apple;
        aborted_d = 1'b0;
      end
      CLEAR: begin
        walls_d = '1;
        idx_d   = '0;
        rej_d   = '0;
        state_d = (tgt_q == 5'd0) ? DONE : GEN;
      end
      GEN: if (rej_c) begin
        rej_d = rej_q + 6'd1;
        // 64th consecutive reject gives up, keeping what was placed so far.
        if (rej_q == 6'd63) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end
      end else begin
        walls_d[idx_q] = lfsr_q;
        idx_d          = idx_q + 5'd1;
        rej_d          = '0;
        if (idx_q + 5'd1 == tgt_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == CLEAR) || (state_d == GEN);
  assign done_d = (state_d == DONE);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q   <= IDLE;
      lfsr_q    <= 8'h01;
      walls_q   <= '1;
      idx_q     <= '0;
      tgt_q     <= '0;
      head_q    <= '0;
      apple_q   <= '0;
      rej_q     <= '0;
      aborted_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      walls_q   <= walls_d;
      idx_q     <= idx_d;
      tgt_q     <= tgt_d;
      head_q    <= head_d;
      apple_q   <= apple_d;
      rej_q     <= rej_d;
      aborted_q <= aborted_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.walls      = walls_q;
  assign bus.wall_count = idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.aborted    = aborted_q;
endmodule

// File: tb/tb_t06_wall_placer.sv
// Scoreboard bench for the wall placer: each run's expected table is predicted at start.
module tb_t06_wall_placer;
  logic clk  = 1'b0;
  logic nRst = 1'b0;
  always #5 clk = ~clk;

  t06_wall_placer_if bus();
  t06_wall_placer dut (.clk(clk), .nRst(nRst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [199:0] walls;
    logic [4:0]   cnt;
    logic         ab;
    int           edges;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_lfsr;

  function automatic logic [7:0] step(input logic [7:0] l);
    return {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
  endfunction

  always @(posedge clk or negedge nRst)
    if (!nRst) m_lfsr <= 8'h01;
    else       m_lfsr <= step(m_lfsr);

  // l0 is the LFSR value in front of the IDLE edge that samples start.
  function automatic exp_t predict(input logic [7:0] l0, input logic [4:0] tc,
                                   input logic [7:0] h, input logic [7:0] a);
    exp_t e; logic [7:0] l, c; int tgt, rej, n; bit dup;
    e.walls = '1; e.cnt = '0; e.ab = 1'b0; e.edges = 2;
    tgt = (tc > 5'd25) ? 25 : int'(tc);
    l = step(step(l0)); rej = 0; n = 0;
    while (tgt != 0 && n != tgt && !e.ab) begin
      c = l; l = step(l); e.edges++; dup = 0;
      for (int j = 0; j < n; j++) if (e.walls[j*8 +: 8] == c) dup = 1;
      if (c == 8'hFF || c == h || c == a || dup) begin
        rej++;
        if (rej == 64) e.ab = 1'b1;
      end else begin
        e.walls[n*8 +: 8] = c; n++; rej = 0;
      end
    end
    e.cnt = 5'(n);
    return e;
  endfunction

  task automatic launch(input logic [4:0] tc, input logic [7:0] h, input logic [7:0] a);
    bus.target_count = tc; bus.snake_head = h; bus.apple = a; bus.start = 1'b1;
    sb.push_back(predict(m_lfsr, tc, h, a));
  endtask

  task automatic wait_done(input bit hold, output int edges, output bit to);
    edges = 0; to = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      if (bus.done === 1'b1) begin edges = k; to = 1'b0; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (bus.walls !== {200{1'b1}}) begin n_fail++; $display("FAIL reset_walls: got %h want all FF", bus.walls); end
    n_chk++; if (bus.wall_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", bus.wall_count); end
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_chk++; if (bus.aborted !== 1'b0) begin n_fail++; $display("FAIL reset_aborted: got %b want 0", bus.aborted); end
  endtask

  task automatic test_basic();
    exp_t e; int ed; bit to; logic [199:0] w;
    w = '1; w[7:0] = 8'h5C; w[15:8] = 8'h17; w[23:16] = 8'hB3;
    nRst = 1'b1;
    launch(5'd3, 8'h2E, 8'h00);
    wait_done(1'b0, ed, to);
    e = sb.pop_front();
    n_chk++; if (to) begin n_fail++; $display("FAIL basic_timeout: got no done want done"); end
    n_chk++; if (ed != 6 || ed != e.edges) begin n_fail++; $display("FAIL basic_latency: got %0d want 6", ed); end
    n_chk++; if (bus.walls !== w) begin n_fail++; $display("FAIL basic_walls: got %h want %h", bus.walls, w); end
    n_chk++; if (bus.wall_count !== 5'd3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", bus.wall_count); end
    n_chk++; if (bus.aborted !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_status: got ab=%b busy=%b want 0 0", bus.aborted, bus.busy); end
    @(negedge clk);
    n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL basic_done_width: got %b want 0", bus.done); end
    n_chk++; if (bus.walls !== w) begin n_fail++; $display("FAIL basic_idle_stable: got %h want %h", bus.walls, w); end
  endtask

  task automatic test_zero();
    exp_t e; int ed; bit to;
    launch(5'd0, 8'h11, 8'h22);
    wait_done(1'b0, ed, to);
    e = sb.pop_front();
    n_chk++; if (to || ed != e.edges) begin n_fail++; $display("FAIL zero_latency: got %0d want %0d", ed, e.edges); end
    n_chk++; if (bus.walls !== e.walls) begin n_fail++; $display("FAIL zero_walls: got %h want %h", bus.walls, e.walls); end
    n_chk++; if (bus.wall_count !== 5'd0) begin n_fail++; $display("FAIL zero_count: got %0d want 0", bus.wall_count); end
    @(negedge clk);
  endtask

  task automatic test_clamp();
    exp_t e; int ed, bad; bit to; logic [7:0] s;
    launch(5'd31, 8'h5C, 8'h17);
    wait_done(1'b0, ed, to);
    e = sb.pop_front();
    n_chk++; if (to || ed != e.edges) begin n_fail++; $display("FAIL clamp_latency: got %0d want %0d", ed, e.edges); end
    n_chk++; if (bus.wall_count !== 5'd25) begin n_fail++; $display("FAIL clamp_count: got %0d want 25", bus.wall_count); end
    n_chk++; if (bus.walls !== e.walls) begin n_fail++; $display("FAIL clamp_walls: got %h want %h", bus.walls, e.walls); end
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      s = bus.walls[i*8 +: 8];
      if (s == 8'hFF || s == 8'h5C || s == 8'h17) bad++;
      for (int j = 0; j < i; j++) if (bus.walls[j*8 +: 8] == s) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL clamp_distinct: got %0d bad slots want 0", bad); end
    @(negedge clk);
  endtask

  task automatic test_start_held();
    exp_t e; int ed; bit to;
    launch(5'd5, 8'h40, 8'h41);
    @(negedge clk);
    bus.target_count = 5'd1; bus.snake_head = 8'h00; bus.apple = 8'h00;
    wait_done(1'b1, ed, to);
    e = sb.pop_front();
    n_chk++; if (to || ed + 1 != e.edges) begin n_fail++; $display("FAIL held_latency: got %0d want %0d", ed + 1, e.edges); end
    n_chk++; if (bus.walls !== e.walls || bus.wall_count !== 5'd5) begin n_fail++; $display("FAIL held_walls: got %h/%0d want %h/5", bus.walls, bus.wall_count, e.walls); end
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL held_done_ignores_start: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    bus.start = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL held_no_rerun: got busy=%b want 0", bus.busy); end
  endtask

  task automatic test_forced_reject();
    exp_t e; int ed; bit to, got; logic [199:0] w;
    launch(5'd10, 8'h2E, 8'h00);
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); bus.start = 1'b0;
      if (bus.wall_count == 5'd2) begin got = 1'b1; break; end
    end
    e = sb.pop_front();
    w = '1; w[15:0] = e.walls[15:0];
    n_chk++; if (!got) begin n_fail++; $display("FAIL force_setup: got count %0d want 2", bus.wall_count); end
    if (got) begin
      force dut.rej_c = 1'b1;
      wait_done(1'b0, ed, to);
      release dut.rej_c;
      n_chk++; if (to || ed != 64) begin n_fail++; $display("FAIL force_latency: got %0d want 64", ed); end
      n_chk++; if (bus.aborted !== 1'b1) begin n_fail++; $display("FAIL force_aborted: got %b want 1", bus.aborted); end
      n_chk++; if (bus.wall_count !== 5'd2 || bus.walls !== w) begin n_fail++; $display("FAIL force_kept: got %h/%0d want %h/2", bus.walls, bus.wall_count, w); end
      @(negedge clk);
      n_chk++; if (bus.aborted !== 1'b1 || bus.done !== 1'b0) begin n_fail++; $display("FAIL force_hold: got ab=%b done=%b want 1 0", bus.aborted, bus.done); end
      launch(5'd0, 8'h11, 8'h22);
      @(negedge clk); bus.start = 1'b0;
      n_chk++; if (bus.aborted !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL force_clear: got ab=%b busy=%b want 0 1", bus.aborted, bus.busy); end
      wait_done(1'b0, ed, to);
      e = sb.pop_front();
      n_chk++; if (to || bus.wall_count !== e.cnt) begin n_fail++; $display("FAIL force_rerun: got %0d want %0d", bus.wall_count, e.cnt); end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_reset();
    exp_t e; int ed; bit to, got; logic [199:0] w;
    w = '1; w[7:0] = 8'h5C; w[15:8] = 8'h17; w[23:16] = 8'hB3;
    launch(5'd3, 8'h2E, 8'h00);
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk); bus.start = 1'b0;
      if (bus.wall_count == 5'd2) begin got = 1'b1; break; end
    end
    void'(sb.pop_front());
    n_chk++; if (!got || bus.busy !== 1'b1) begin n_fail++; $display("FAIL midrst_setup: got count %0d busy %b want 2 1", bus.wall_count, bus.busy); end
    nRst = 1'b0;
    #1;
    n_chk++; if (bus.walls !== {200{1'b1}} || bus.wall_count !== 5'd0) begin n_fail++; $display("FAIL midrst_table: got %h/%0d want all FF/0", bus.walls, bus.wall_count); end
    n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.aborted !== 1'b0) begin n_fail++; $display("FAIL midrst_status: got %b%b%b want 000", bus.busy, bus.done, bus.aborted); end
    #1;
    nRst = 1'b1;
    launch(5'd3, 8'h2E, 8'h00);
    wait_done(1'b0, ed, to);
    e = sb.pop_front();
    n_chk++; if (to || ed != 6 || ed != e.edges) begin n_fail++; $display("FAIL midrst_latency: got %0d want 6", ed); end
    n_chk++; if (bus.walls !== w || bus.wall_count !== 5'd3) begin n_fail++; $display("FAIL midrst_walls: got %h/%0d want %h/3", bus.walls, bus.wall_count, w); end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.target_count = '0; bus.snake_head = '0; bus.apple = '0;
    test_reset();
    test_basic();
    test_zero();
    test_clamp();
    test_start_held();
    test_forced_reject();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
